// File: rtl/snitch_icache_l0_refill_arbiter.sv
// snitch_icache_l0_refill_arbiter: shares one L1 refill channel among NR_PORTS L0 caches with
// demand-first round-robin, per-port outstanding limits and ID-based response routing.
module snitch_icache_l0_refill_arbiter #(
   parameter int NR_PORTS        = 4,
   parameter int FETCH_AW        = 32,
   parameter int LINE_WIDTH      = 128,
   parameter int MAX_OUTSTANDING = 2,
   parameter int ID_WIDTH        = $clog2(NR_PORTS) + 1
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic [NR_PORTS-1:0][FETCH_AW-1:0] in_req_addr_i,
   input  logic [NR_PORTS-1:0]               in_req_prefetch_i,
   input  logic [NR_PORTS-1:0]               in_req_valid_i,
   output logic [NR_PORTS-1:0]               in_req_ready_o,
   output logic [LINE_WIDTH-1:0]             in_rsp_data_o,
   output logic                              in_rsp_error_o,
   output logic                              in_rsp_prefetch_o,
   output logic [NR_PORTS-1:0]               in_rsp_valid_o,
   input  logic [NR_PORTS-1:0]               in_rsp_ready_i,
   output logic [FETCH_AW-1:0]               out_req_addr_o,
   output logic [ID_WIDTH-1:0]               out_req_id_o,
   output logic                              out_req_valid_o,
   input  logic                              out_req_ready_i,
   input  logic [LINE_WIDTH-1:0]             out_rsp_data_i,
   input  logic                              out_rsp_error_i,
   input  logic [ID_WIDTH-1:0]               out_rsp_id_i,
   input  logic                              out_rsp_valid_i,
   output logic                              out_rsp_ready_o
);
   localparam int PW = ID_WIDTH - 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   logic [NR_PORTS-1:0][CW-1:0] r_cnt;
   logic [PW-1:0]               r_rr;
   logic                        r_out_valid;
   logic [FETCH_AW-1:0]         r_out_addr;
   logic [ID_WIDTH-1:0]         r_out_id;
   logic [NR_PORTS-1:0]         w_elig, w_dem, w_cand, w_rsp_hs;
   logic [PW-1:0]               w_sel, w_p;
   logic                        w_found, w_gnt, w_pok;
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < NR_PORTS; i++)
         w_elig[i] = in_req_valid_i[i] && (r_cnt[i] < CW'(MAX_OUTSTANDING));
      w_dem  = w_elig & ~in_req_prefetch_i;
      w_cand = |w_dem ? w_dem : w_elig;
   end
   // Scan offsets from the top down so the smallest offset from r_rr is the one left standing.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      for (int k = NR_PORTS - 1; k >= 0; k--)
         if (w_cand[(int'(r_rr) + k) % NR_PORTS]) begin
            w_found = 1'b1;
            w_sel   = PW'((int'(r_rr) + k) % NR_PORTS);
         end
   end
   assign w_gnt          = !rst_i && w_found && (!r_out_valid || out_req_ready_i);
   assign in_req_ready_o = w_gnt ? NR_PORTS'(1) << w_sel : '0;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_out_valid <= 1'b0;
         r_rr        <= '0;
      end else if (w_gnt) begin
         r_out_valid <= 1'b1;
         r_out_addr  <= in_req_addr_i[w_sel];
         r_out_id    <= {w_sel, in_req_prefetch_i[w_sel]};
         r_rr        <= (int'(w_sel) == NR_PORTS - 1) ? '0 : w_sel + 1'b1;
      end else if (out_req_ready_i) begin
         r_out_valid <= 1'b0;
      end
   end
   assign out_req_valid_o = r_out_valid;
   assign out_req_addr_o  = r_out_addr;
   assign out_req_id_o    = r_out_id;
   assign w_p               = out_rsp_id_i[ID_WIDTH-1:1];
   assign w_pok             = int'(w_p) < NR_PORTS;
   assign in_rsp_valid_o    = (!rst_i && out_rsp_valid_i && w_pok) ? NR_PORTS'(1) << w_p : '0;
   assign out_rsp_ready_o   = !rst_i && (!w_pok || in_rsp_ready_i[w_p]);
   assign in_rsp_prefetch_o = out_rsp_id_i[0];
   assign in_rsp_data_o     = out_rsp_data_i;
   assign in_rsp_error_o    = out_rsp_error_i;
   assign w_rsp_hs          = out_rsp_ready_o ? in_rsp_valid_o : '0;
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NR_PORTS; i++)
         if (rst_i) r_cnt[i] <= '0;
         else if (in_req_ready_o[i] && !w_rsp_hs[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
         else if (!in_req_ready_o[i] && w_rsp_hs[i]) r_cnt[i] <= r_cnt[i] - 1'b1;
   end
   assert property (@(posedge clk_i) $onehot0(in_req_ready_o));
   assert property (@(posedge clk_i) disable iff (rst_i)
      out_req_valid_o && !out_req_ready_i |=> out_req_valid_o && $stable(out_req_addr_o) && $stable(out_req_id_o));
   assert property (@(posedge clk_i) disable iff (rst_i)
      out_rsp_valid_i |-> w_pok && r_cnt[w_p] != '0);
endmodule

// File: tb/tb_snitch_icache_l0_refill_arbiter.sv
// tb_snitch_icache_l0_refill_arbiter: directed scenario tasks with hand-computed expectations
// for the refill arbiter (4 ports, 2 outstanding per port).
module tb_snitch_icache_l0_refill_arbiter;
   localparam int NP = 4, AW = 32, LW = 128, MO = 2, IW = 3;
   logic clk = 1'b0, rst = 1'b1;
   logic [NP-1:0][AW-1:0] in_req_addr;
   logic [NP-1:0] in_req_prefetch, in_req_valid, in_req_ready, in_rsp_valid, in_rsp_ready;
   logic [LW-1:0] in_rsp_data, out_rsp_data;
   logic in_rsp_error, in_rsp_prefetch, out_req_valid, out_req_ready, out_rsp_error, out_rsp_valid, out_rsp_ready;
   logic [AW-1:0] out_req_addr;
   logic [IW-1:0] out_req_id, out_rsp_id;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   snitch_icache_l0_refill_arbiter #(
      .NR_PORTS(NP), .FETCH_AW(AW), .LINE_WIDTH(LW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .in_req_addr_i(in_req_addr), .in_req_prefetch_i(in_req_prefetch), .in_req_valid_i(in_req_valid),
      .in_req_ready_o(in_req_ready), .in_rsp_data_o(in_rsp_data), .in_rsp_error_o(in_rsp_error),
      .in_rsp_prefetch_o(in_rsp_prefetch), .in_rsp_valid_o(in_rsp_valid), .in_rsp_ready_i(in_rsp_ready),
      .out_req_addr_o(out_req_addr), .out_req_id_o(out_req_id), .out_req_valid_o(out_req_valid),
      .out_req_ready_i(out_req_ready), .out_rsp_data_i(out_rsp_data), .out_rsp_error_i(out_rsp_error),
      .out_rsp_id_i(out_rsp_id), .out_rsp_valid_i(out_rsp_valid), .out_rsp_ready_o(out_rsp_ready)
   );
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   task automatic clear;
      in_req_addr = '0; in_req_prefetch = '0; in_req_valid = '0; in_rsp_ready = '0;
      out_req_ready = 1'b0; out_rsp_data = '0; out_rsp_error = 1'b0; out_rsp_id = '0; out_rsp_valid = 1'b0;
   endtask
   task automatic do_reset;
      clear();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask
   task automatic test_reset;
      clear();
      rst = 1'b1; in_req_valid = '1; out_req_ready = 1'b1; out_rsp_valid = 1'b1; in_rsp_ready = '1;
      cyc(); cyc();
      checks++; if (out_req_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_req_valid); end
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b exp 0000", in_req_ready); end
      checks++; if (in_rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0000", in_rsp_valid); end
      checks++; if (out_rsp_ready !== 1'b0) begin errors++; $display("FAIL reset_rsp_ready got %b exp 0", out_rsp_ready); end
      clear();
      rst = 1'b0;
   endtask
   task automatic test_round_robin;
      do_reset();
      in_req_valid = '1; out_req_ready = 1'b1;
      for (int i = 0; i < NP; i++) in_req_addr[i] = 32'h100 * (i + 1);
      #1;
      for (int k = 0; k < 5; k++) begin
         automatic logic [3:0] er = 4'b0001 << (k % 4);
         automatic logic [IW-1:0] ei = IW'(2 * (k % 4));
         automatic logic [AW-1:0] ea = 32'h100 * (k % 4 + 1);
         checks++; if (in_req_ready !== er) begin errors++; $display("FAIL rr_ready k=%0d got %b exp %b", k, in_req_ready, er); end
         cyc();
         checks++;
         if (out_req_valid !== 1'b1 || out_req_id !== ei || out_req_addr !== ea) begin
            errors++; $display("FAIL rr_out k=%0d got v=%b id=%h a=%h exp v=1 id=%h a=%h", k, out_req_valid, out_req_id, out_req_addr, ei, ea);
         end
      end
   endtask
   task automatic test_demand_priority;
      do_reset();
      out_req_ready = 1'b1; in_req_valid = 4'b0110; in_req_prefetch = 4'b0010;
      in_req_addr[1] = 32'h1000; in_req_addr[2] = 32'h2000;
      #1;
      checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL prio_ready1 got %b exp 0100", in_req_ready); end
      cyc();
      checks++; if (out_req_id !== 3'h4 || out_req_addr !== 32'h2000) begin errors++; $display("FAIL prio_out1 got id=%h a=%h exp id=4 a=2000", out_req_id, out_req_addr); end
      in_req_valid = 4'b0010;
      #1;
      checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL prio_ready2 got %b exp 0010", in_req_ready); end
      cyc();
      checks++; if (out_req_id !== 3'h3 || out_req_addr !== 32'h1000) begin errors++; $display("FAIL prio_out2 got id=%h a=%h exp id=3 a=1000", out_req_id, out_req_addr); end
      in_req_valid = '0;
      cyc();
      checks++; if (out_req_valid !== 1'b0) begin errors++; $display("FAIL prio_drain got %b exp 0", out_req_valid); end
   endtask
   task automatic test_outstanding;
      do_reset();
      out_req_ready = 1'b1; in_req_valid = 4'b0001; in_req_addr[0] = 32'h40;
      #1;
      checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL lim_ready0 got %b exp 0001", in_req_ready); end
      cyc();
      checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL lim_ready1 got %b exp 0001", in_req_ready); end
      cyc();
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL lim_ready2 got %b exp 0000", in_req_ready); end
      cyc();
      checks++; if (out_req_valid !== 1'b0 || in_req_ready !== 4'b0000) begin errors++; $display("FAIL lim_blocked got v=%b r=%b exp v=0 r=0000", out_req_valid, in_req_ready); end
      out_rsp_valid = 1'b1; out_rsp_id = 3'h0; in_rsp_ready = 4'b0001; out_rsp_error = 1'b1;
      out_rsp_data = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
      #1;
      checks++; if (in_rsp_valid !== 4'b0001 || out_rsp_ready !== 1'b1 || in_rsp_prefetch !== 1'b0) begin
         errors++; $display("FAIL lim_rsp got v=%b rdy=%b pf=%b exp v=0001 rdy=1 pf=0", in_rsp_valid, out_rsp_ready, in_rsp_prefetch);
      end
      checks++; if (in_rsp_data !== 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 || in_rsp_error !== 1'b1) begin
         errors++; $display("FAIL lim_rsp_data got d=%h e=%b exp d=0123456789abcdeffedcba9876543210 e=1", in_rsp_data, in_rsp_error);
      end
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL lim_same_cycle got %b exp 0000", in_req_ready); end
      cyc();
      out_rsp_valid = 1'b0;
      #1;
      checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL lim_regain got %b exp 0001", in_req_ready); end
      cyc();
      checks++; if (out_req_valid !== 1'b1 || out_req_id !== 3'h0 || in_req_ready !== 4'b0000) begin
         errors++; $display("FAIL lim_refill got v=%b id=%h r=%b exp v=1 id=0 r=0000", out_req_valid, out_req_id, in_req_ready);
      end
   endtask
   task automatic test_back_to_back;
      do_reset();
      in_req_valid = 4'b0011; in_req_addr[0] = 32'hA0; in_req_addr[1] = 32'hB0;
      #1;
      checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL bp_ready0 got %b exp 0001", in_req_ready); end
      cyc();
      for (int s = 0; s < 5; s++) begin
         checks++;
         if (in_req_ready !== 4'b0000 || out_req_valid !== 1'b1 || out_req_addr !== 32'hA0 || out_req_id !== 3'h0) begin
            errors++; $display("FAIL bp_stall s=%0d got r=%b v=%b a=%h id=%h exp r=0000 v=1 a=a0 id=0", s, in_req_ready, out_req_valid, out_req_addr, out_req_id);
         end
         cyc();
      end
      out_req_ready = 1'b1;
      #1;
      checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got %b exp 0010", in_req_ready); end
      cyc();
      checks++; if (out_req_valid !== 1'b1 || out_req_addr !== 32'hB0 || out_req_id !== 3'h2) begin
         errors++; $display("FAIL bp_refill got v=%b a=%h id=%h exp v=1 a=b0 id=2", out_req_valid, out_req_addr, out_req_id);
      end
   endtask
   task automatic test_response_routing;
      do_reset();
      out_req_ready = 1'b1; in_req_valid = 4'b0100; in_req_prefetch = 4'b0100; in_req_addr[2] = 32'h300;
      #1;
      checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL rsp_pf_ready got %b exp 0100", in_req_ready); end
      cyc();
      in_req_valid = '0; in_req_prefetch = '0;
      checks++; if (out_req_id !== 3'h5) begin errors++; $display("FAIL rsp_pf_id got %h exp 5", out_req_id); end
      out_rsp_valid = 1'b1; out_rsp_id = 3'h5; in_rsp_ready = 4'b1011;
      for (int s = 0; s < 2; s++) begin
         #1;
         checks++; if (in_rsp_valid !== 4'b0100 || in_rsp_prefetch !== 1'b1 || out_rsp_ready !== 1'b0) begin
            errors++; $display("FAIL rsp_wait s=%0d got v=%b pf=%b rdy=%b exp v=0100 pf=1 rdy=0", s, in_rsp_valid, in_rsp_prefetch, out_rsp_ready);
         end
         cyc();
      end
      in_rsp_ready = 4'b1111;
      #1;
      checks++; if (out_rsp_ready !== 1'b1) begin errors++; $display("FAIL rsp_ready got %b exp 1", out_rsp_ready); end
      cyc();
      out_rsp_valid = 1'b0; in_req_valid = 4'b0100;
      #1;
      checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL rsp_cnt0 got %b exp 0100", in_req_ready); end
      cyc();
      checks++; if (in_req_ready !== 4'b0100) begin errors++; $display("FAIL rsp_cnt1 got %b exp 0100", in_req_ready); end
      cyc();
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL rsp_cnt2 got %b exp 0000", in_req_ready); end
   endtask
   task automatic test_reset_mid;
      do_reset();
      in_req_valid = 4'b0110; in_req_addr[1] = 32'h50;
      #1;
      checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL mid_ready got %b exp 0010", in_req_ready); end
      cyc();
      checks++; if (out_req_valid !== 1'b1 || out_req_id !== 3'h2) begin errors++; $display("FAIL mid_held got v=%b id=%h exp v=1 id=2", out_req_valid, out_req_id); end
      rst = 1'b1;
      #1;
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b exp 0000", in_req_ready); end
      cyc();
      rst = 1'b0; in_req_valid = 4'b1111; out_req_ready = 1'b1;
      #1;
      checks++; if (out_req_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", out_req_valid); end
      checks++; if (in_req_ready !== 4'b0001) begin errors++; $display("FAIL mid_restart got %b exp 0001", in_req_ready); end
      in_req_valid = 4'b0010;
      #1;
      checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL mid_cnt0 got %b exp 0010", in_req_ready); end
      cyc();
      checks++; if (in_req_ready !== 4'b0010) begin errors++; $display("FAIL mid_cnt1 got %b exp 0010", in_req_ready); end
      cyc();
      checks++; if (in_req_ready !== 4'b0000) begin errors++; $display("FAIL mid_cnt2 got %b exp 0000", in_req_ready); end
   endtask
   initial begin
      clear();
      test_reset();
      test_round_robin();
      test_demand_priority();
      test_outstanding();
      test_back_to_back();
      test_response_routing();
      test_reset_mid();
      do_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
